// File: rtl/sseg_scan_ctrl.sv
// Four-digit active-low hex scan controller with tear-free frame-boundary display updates.
// Optional leading-zero blanking is enabled by defining SSEG_LZB_EN.
module sseg_scan_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        LOAD,
    input  logic        BLANK,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        FRAME_DONE
);
    localparam int            CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

`ifdef SSEG_LZB_EN
    // A digit is visible if it or any more-significant nibble is nonzero; digit 0 always shows.
    function automatic logic [3:0] digit_visible(input logic [15:0] v);
        logic [3:0] m;
        m[0] = 1'b1;
        m[1] = |v[15:4];
        m[2] = |v[15:8];
        m[3] = |v[15:12];
        return m;
    endfunction
`endif

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic          tick_s;
    logic          boundary_s;
    logic [3:0]    nib_s;
    logic [3:0]    show_s;

    // Prescaler, digit sequencing, pending buffer and next output values.
    always_comb begin
        tick_s       = (cnt_q == CNT_MAX);
        boundary_s   = tick_s && (dig_q == 2'd3);
        cnt_d        = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
        dig_d        = tick_s ? dig_q + 2'd1 : dig_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        frame_done_d = boundary_s;

        // A LOAD landing on the boundary goes straight to the display, superseding any pending value.
        if (boundary_s) begin
            if (LOAD) begin
                disp_d   = DATA;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                disp_d   = pend_q;
                pend_v_d = 1'b0;
            end else begin
                disp_d   = disp_q;
            end
        end else if (LOAD) begin
            pend_d   = DATA;
            pend_v_d = 1'b1;
        end else begin
            pend_d   = pend_q;
        end

        nib_s = disp_q[{dig_q, 2'b00} +: 4];
        seg_d = hex7(nib_s);
`ifdef SSEG_LZB_EN
        show_s = digit_visible(disp_q);
`else
        show_s = 4'b1111;
`endif
        if (BLANK) begin
            an_d = 4'b1111;
        end else begin
            an_d = ~((4'b0001 << dig_q) & show_s);
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q        <= {CW{1'b0}};
            dig_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_v_q     <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl with TICK_DIV=4 (16-cycle frames).
// Expected {AN,SEG,FRAME_DONE} per edge index are queued by the stimulus and checked by a monitor.
module tb_sseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int n = 0;

    int          exp_n[$];
    logic [11:0] exp_v[$];

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    sseg_scan_ctrl #(.TICK_DIV(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .DATA       (data),
        .LOAD       (load),
        .BLANK      (blank),
        .SEG        (seg),
        .AN         (an),
        .FRAME_DONE (frame_done)
    );

    always #5 clk = ~clk;

    // Edge index since reset release: after edge n the outputs belong to slot (n-1)/4.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // Monitor: pop and compare whenever the DUT presents the output for a queued edge index.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_n.size() > 0 && exp_n[0] < n) begin
                tests++;
                fails++;
                $display("FAIL missed_check n=%0d (now %0d)", exp_n[0], n);
                void'(exp_n.pop_front());
                void'(exp_v.pop_front());
            end
            if (exp_n.size() > 0 && exp_n[0] == n) begin
                logic [11:0] e;
                e = exp_v.pop_front();
                void'(exp_n.pop_front());
                tests++;
                if ({an, seg, frame_done} !== e) begin
                    fails++;
                    $display("FAIL scan n=%0d got AN=%b SEG=%b FD=%b exp AN=%b SEG=%b FD=%b",
                             n, an, seg, frame_done, e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    task automatic push_frame(input int f, input logic [15:0] d, input int blo, input int bhi);
        for (int i = 1; i <= 16; i++) begin
            int         nn;
            int         s;
            logic [3:0] a;
            logic [3:0] nib;
            nn  = 16 * f + i;
            s   = (i - 1) / 4;
            nib = d[4*s +: 4];
            a   = ~(4'b0001 << s);
`ifdef SSEG_LZB_EN
            if (s != 0 && (d >> (4 * s)) == 16'h0000) a = 4'b1111;
`endif
            if (nn >= blo && nn <= bhi) a = 4'b1111;
            exp_n.push_back(nn);
            exp_v.push_back({a, HEX[nib], (i == 16)});
        end
    endtask

    task automatic wait_n(input int m);
        int guard;
        guard = 0;
        while (n < m && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (n != m) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout got n=%0d exp %0d", n, m);
        end
    endtask

    // Drive LOAD so that it is sampled by edge m.
    task automatic load_at(input int m, input logic [15:0] d);
        wait_n(m - 1);
        load = 1'b1;
        data = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({an, seg, frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            fails++;
            $display("FAIL %s got AN=%b SEG=%b FD=%b exp AN=1111 SEG=1111111 FD=0",
                     tag, an, seg, frame_done);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_reset_outputs("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Frame 0 shows 0000; LOAD 1234 mid-frame becomes visible in frame 1.
        push_frame(0, 16'h0000, 0, -1);
        push_frame(1, 16'h1234, 0, -1);
        load_at(3, 16'h1234);

        // LOAD ABCD while digit 1 is displayed: frame 2 stays 1234.
        push_frame(2, 16'h1234, 0, -1);
        push_frame(3, 16'hABCD, 0, -1);
        load_at(38, 16'hABCD);

        // Pending 1111, then 2222 on the boundary edge wins and clears the pending flag.
        push_frame(4, 16'hABCD, 0, -1);
        push_frame(5, 16'h2222, 0, -1);
        push_frame(6, 16'h2222, 0, -1);
        load_at(70, 16'h1111);
        load_at(80, 16'h2222);

        // BLANK sampled by edges 113..152: anodes off, FRAME_DONE and SEG unaffected.
        push_frame(7, 16'h2222, 113, 152);
        push_frame(8, 16'h2222, 113, 152);
        push_frame(9, 16'h2222, 113, 152);
        wait_n(112);
        blank = 1'b1;
        wait_n(152);
        blank = 1'b0;

        // Leading-zero cases, loaded on boundary edges.
        push_frame(10, 16'h0040, 0, -1);
        push_frame(11, 16'h0000, 0, -1);
        push_frame(12, 16'h0000, 0, -1);
        load_at(160, 16'h0040);
        load_at(176, 16'h0000);

        // Leave 5555 pending, then reset mid-scan right after a FRAME_DONE pulse.
        load_at(200, 16'h5555);
        wait_n(208);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_midscan");
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(negedge clk);
        push_frame(0, 16'h0000, 0, -1);
        push_frame(1, 16'h0000, 0, -1);
        rst = 1'b0;
        wait_n(32);
        @(negedge clk);

        tests++;
        if (exp_n.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got %0d left exp 0", exp_n.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
